// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: oversampling constants, FSM states, vote helper.
package uart_pkg;

   localparam int unsigned OVS      = 16;
   localparam int unsigned MID_TICK = 8;
   localparam int unsigned SUB_W    = $clog2(OVS);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2,
      StDone
   } rx_state_e;

   // Two-of-three majority used to reject single-sample noise within a bit cell.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every div+1 clocks, held at phase zero while clr is high.
module uart_baud_tick #(
   parameter int unsigned DIV_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;

   assign tick = ~clr & (cnt_q == div);

   // Divider counter; restarts on clear and at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling, start validation, 5..8 data bits, parity/stop checks and a
// valid/ready output register with error pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W    = 12,
   parameter int unsigned MAJ_VOTE = 1
) (
   input  logic             app_clk,
   input  logic             reset_n,
   input  logic             cfg_rx_en,
   input  logic [DIV_W-1:0] cfg_baud_div,
   input  logic [1:0]       cfg_data_bit,
   input  logic             cfg_stop_bit,
   input  logic             cfg_par_en,
   input  logic             cfg_even_par,
   input  logic             rxd,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             err_frame,
   output logic             err_parity,
   output logic             err_overrun
);

   // With voting the bit decision lands on the last of the three samples.
   localparam int unsigned DEC_TICK = (MAJ_VOTE != 0) ? MID_TICK + 1 : MID_TICK;

   logic [1:0]       sync_q;
   logic             rxd_s, rxd_prev_q, start_edge;
   rx_state_e        state_q, state_d;
   logic [SUB_W-1:0] sub_cnt_q;
   logic [2:0]       bit_cnt_q, last_idx;
   logic [7:0]       shreg_q;
   logic             data_xor_q, par_err_q, frm_err_q, samp0_q, samp1_q;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       nbits_q;
   logic             stop2_q, par_en_q, even_q;
   logic             tick, tick_clr, dec, bit_val;
   logic             start_go, shift_en, par_chk, stop_chk, done;

   assign rxd_s      = sync_q[1];
   assign start_edge = rxd_prev_q & ~rxd_s;
   assign dec        = tick & (sub_cnt_q == SUB_W'(DEC_TICK));
   assign bit_val    = (MAJ_VOTE != 0) ? maj3(samp0_q, samp1_q, rxd_s) : rxd_s;
   assign last_idx   = {1'b0, nbits_q} + 3'd4;

   uart_baud_tick #(
      .DIV_W(DIV_W)
   ) u_baud_tick (
      .clk  (app_clk),
      .rst_n(reset_n),
      .clr  (tick_clr),
      .div  (div_q),
      .tick (tick)
   );

   // Two-flop synchronizer plus edge-detect history, all idling high like the line.
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= 2'b11;
         rxd_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rxd_prev_q <= rxd_s;
      end
   end

   // FSM state register.
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // FSM next state; dropping the enable aborts any frame in flight.
   always_comb begin
      state_d = state_q;
      if (!cfg_rx_en && state_q != StIdle && state_q != StDone) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   if (cfg_rx_en && start_edge) state_d = StStart;
            StStart:  if (dec) state_d = bit_val ? StIdle : StData;
            StData:   if (dec && bit_cnt_q == last_idx) state_d = par_en_q ? StParity : StStop1;
            StParity: if (dec) state_d = StStop1;
            StStop1:  if (dec) state_d = stop2_q ? StStop2 : StDone;
            StStop2:  if (dec) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // FSM decoded controls for the datapath.
   always_comb begin
      tick_clr = (state_q == StIdle);
      start_go = (state_q == StIdle) && (state_d == StStart);
      shift_en = (state_q == StData) && dec;
      par_chk  = (state_q == StParity) && dec;
      stop_chk = ((state_q == StStop1) || (state_q == StStop2)) && dec;
      done     = (state_q == StDone);
   end

   // Frame datapath: config latch, sub-tick phase, sample capture, shift and error accumulation.
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q      <= '0;
         nbits_q    <= '0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         even_q     <= 1'b0;
         sub_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_xor_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         samp0_q    <= 1'b1;
         samp1_q    <= 1'b1;
      end else if (start_go) begin
         div_q      <= cfg_baud_div;
         nbits_q    <= cfg_data_bit;
         stop2_q    <= cfg_stop_bit;
         par_en_q   <= cfg_par_en;
         even_q     <= cfg_even_par;
         sub_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_xor_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         if (tick) begin
            sub_cnt_q <= sub_cnt_q + SUB_W'(1);
            if (sub_cnt_q == SUB_W'(MID_TICK - 1)) samp0_q <= rxd_s;
            if (sub_cnt_q == SUB_W'(MID_TICK))     samp1_q <= rxd_s;
         end
         if (shift_en) begin
            shreg_q[bit_cnt_q] <= bit_val;
            data_xor_q         <= data_xor_q ^ bit_val;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
         end
         if (par_chk)             par_err_q <= (data_xor_q ^ bit_val) != ~even_q;
         if (stop_chk && !bit_val) frm_err_q <= 1'b1;
      end
   end

   // Output register: deliver or drop on frame end; a same-cycle accept frees the slot.
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_frame   <= done & frm_err_q;
         err_parity  <= done & par_err_q;
         err_overrun <= done & rx_valid & ~rx_ready;
         if (done && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg_q;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame scenarios and randomized frames against a frame-level model.
module tb_uart_rx_core;

   logic        app_clk = 1'b0;
   logic        reset_n;
   logic        cfg_rx_en;
   logic [11:0] cfg_baud_div;
   logic [1:0]  cfg_data_bit;
   logic        cfg_stop_bit;
   logic        cfg_par_en;
   logic        cfg_even_par;
   logic        rxd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        err_frame;
   logic        err_parity;
   logic        err_overrun;

   int n_vec = 0;
   int n_err = 0;
   int n_frame = 0, n_par = 0, n_ovr = 0;
   int e_frame = 0, e_par = 0, e_ovr = 0;
   int cur_div = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_rx_core dut (
      .app_clk     (app_clk),
      .reset_n     (reset_n),
      .cfg_rx_en   (cfg_rx_en),
      .cfg_baud_div(cfg_baud_div),
      .cfg_data_bit(cfg_data_bit),
      .cfg_stop_bit(cfg_stop_bit),
      .cfg_par_en  (cfg_par_en),
      .cfg_even_par(cfg_even_par),
      .rxd         (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .err_frame   (err_frame),
      .err_parity  (err_parity),
      .err_overrun (err_overrun)
   );

   always #5 app_clk = ~app_clk;

   // Consumer side: record accepted bytes and count error pulses.
   always @(negedge app_clk) begin
      if (reset_n) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (err_frame)   n_frame = n_frame + 1;
         if (err_parity)  n_par   = n_par + 1;
         if (err_overrun) n_ovr   = n_ovr + 1;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish in time, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      @(negedge app_clk) rxd = v;
      repeat (n - 1) @(negedge app_clk);
   endtask

   task automatic set_cfg(input int div, input int db, input bit st2, input bit pe, input bit ev);
      @(negedge app_clk);
      cur_div      = div;
      cfg_baud_div = 12'(div);
      cfg_data_bit = 2'(db);
      cfg_stop_bit = st2;
      cfg_par_en   = pe;
      cfg_even_par = ev;
   endtask

   task automatic set_ready(input logic v);
      @(posedge app_clk);
      #1 rx_ready = v;
   endtask

   // Agent-style frame writer; scramble perturbs cfg after the start bit.
   task automatic send(input logic [7:0] d, input int nb, input bit pe, input bit agent_even,
                       input bit st2, input bit stop_low, input bit scramble);
      int bt;
      logic [7:0] m;
      logic p;
      bt = 16 * (cur_div + 1);
      m  = 8'((1 << nb) - 1);
      drive(1'b0, bt);
      if (scramble) begin
         cfg_data_bit = 2'($urandom);
         cfg_stop_bit = 1'($urandom);
         cfg_par_en   = 1'($urandom);
         cfg_even_par = 1'($urandom);
         cfg_baud_div = 12'($urandom_range(0, 7));
      end
      for (int i = 0; i < nb; i++) drive(d[i], bt);
      if (pe) begin
         p = ^(d & m);
         drive(agent_even ? p : ~p, bt);
      end
      drive(~stop_low, bt);
      if (st2) drive(~stop_low, bt);
      @(negedge app_clk) rxd = 1'b1;
   endtask

   task automatic check_all(input string tag);
      int t;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 3000) begin
         @(negedge app_clk);
         t++;
      end
      repeat (8) @(negedge app_clk);
      chk({tag, "/count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         chk({tag, "/data"}, got_q.pop_front(), exp_q.pop_front());
      end
      got_q.delete();
      exp_q.delete();
      chk({tag, "/err_frame"}, n_frame, e_frame);
      chk({tag, "/err_parity"}, n_par, e_par);
      chk({tag, "/err_overrun"}, n_ovr, e_ovr);
   endtask

   initial begin
      int db, nb, bt;
      bit st2, pe, ev, aev, sl, scr;
      logic [7:0] d;

      reset_n      = 1'b0;
      rxd          = 1'b1;
      rx_ready     = 1'b1;
      cfg_rx_en    = 1'b1;
      cfg_baud_div = '0;
      cfg_data_bit = 2'd3;
      cfg_stop_bit = 1'b0;
      cfg_par_en   = 1'b0;
      cfg_even_par = 1'b0;
      repeat (3) @(negedge app_clk);
      chk("reset/rx_data", rx_data, 8'h00);
      chk("reset/rx_valid", rx_valid, 1'b0);
      chk("reset/err", {err_frame, err_parity, err_overrun}, 3'b000);
      reset_n = 1'b1;
      drive(1'b1, 20);

      // 8N1 single byte
      set_cfg(0, 3, 0, 0, 0);
      exp_q.push_back(8'hA5);
      send(8'hA5, 8, 0, 0, 0, 0, 0);
      check_all("8n1");

      // 7E2 back-to-back
      set_cfg(0, 2, 1, 1, 1);
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h7F);
      send(8'h41, 7, 1, 1, 1, 0, 0);
      send(8'h7F, 7, 1, 1, 1, 0, 0);
      check_all("7e2");

      // 8O1 receiver, agent sends even parity
      set_cfg(0, 3, 0, 1, 0);
      exp_q.push_back(8'h03);
      e_par++;
      send(8'h03, 8, 1, 1, 0, 0, 0);
      check_all("parity");

      // Stop bit error
      set_cfg(0, 3, 0, 0, 0);
      exp_q.push_back(8'h55);
      e_frame++;
      send(8'h55, 8, 0, 0, 0, 1, 0);
      drive(1'b1, 16);
      check_all("stop");

      // Break: line held low well past the stop bit yields one byte with frame error
      exp_q.push_back(8'h00);
      e_frame++;
      drive(1'b0, 16 * 14);
      drive(1'b1, 32);
      check_all("break");

      // Overrun while consumer stalls
      set_ready(1'b0);
      exp_q.push_back(8'h11);
      e_ovr++;
      send(8'h11, 8, 0, 0, 0, 0, 0);
      drive(1'b1, 16);
      send(8'h22, 8, 0, 0, 0, 0, 0);
      drive(1'b1, 32);
      chk("ovr/valid", rx_valid, 1'b1);
      chk("ovr/data", rx_data, 8'h11);
      chk("ovr/pulse", n_ovr, e_ovr);
      set_ready(1'b1);
      repeat (3) @(negedge app_clk);
      chk("ovr/drop", rx_valid, 1'b0);
      check_all("ovr");

      // Short low glitch on idle line is a false start
      drive(1'b0, 3);
      drive(1'b1, 60);
      check_all("glitch");

      // Enable dropped mid-frame: nothing delivered
      drive(1'b0, 16);
      drive(1'b1, 16);
      drive(1'b0, 16);
      cfg_rx_en = 1'b0;
      drive(1'b1, 16);
      drive(1'b0, 16 * 6);
      drive(1'b1, 40);
      cfg_rx_en = 1'b1;
      drive(1'b1, 16);
      check_all("abort");

      // Reset mid-byte with a held byte pending
      set_ready(1'b0);
      send(8'h5A, 8, 0, 0, 0, 0, 0);
      drive(1'b1, 16);
      chk("rst/pre_valid", rx_valid, 1'b1);
      drive(1'b0, 16);
      drive(1'b1, 16);
      drive(1'b1, 16);
      @(negedge app_clk);
      reset_n = 1'b0;
      rxd     = 1'b1;
      repeat (2) @(negedge app_clk);
      chk("rst/rx_valid", rx_valid, 1'b0);
      chk("rst/rx_data", rx_data, 8'h00);
      chk("rst/err", {err_frame, err_parity, err_overrun}, 3'b000);
      rx_ready = 1'b1;
      @(negedge app_clk);
      reset_n = 1'b1;
      drive(1'b1, 32);
      exp_q.push_back(8'hC3);
      send(8'hC3, 8, 0, 0, 0, 0, 0);
      check_all("rst/after");

      // Randomized frames against the frame-level model
      for (int k = 0; k < 24; k++) begin
         db  = int'($urandom_range(0, 3));
         nb  = db + 5;
         st2 = 1'($urandom);
         pe  = 1'($urandom);
         ev  = 1'($urandom);
         aev = ($urandom_range(0, 4) == 0) ? ~ev : ev;
         sl  = ($urandom_range(0, 5) == 0);
         scr = 1'($urandom);
         d   = 8'($urandom);
         set_cfg(int'($urandom_range(0, 3)), db, st2, pe, ev);
         bt  = 16 * (cur_div + 1);
         exp_q.push_back(d & 8'((1 << nb) - 1));
         if (pe && aev != ev) e_par++;
         if (sl) e_frame++;
         send(d, nb, pe, aev, st2, sl, scr);
         drive(1'b1, bt);
         check_all("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
